// File: rtl/goldschmidt_pkg.sv
// rtl/goldschmidt_pkg.sv - shared widths, product slice bounds and state encoding for the Goldschmidt divider
package goldschmidt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Sticky round-up looks at this many bits below the quotient LSB
  localparam int ROUND_BITS = 3;

  function automatic int iw(input int w);
    return 2 * w;
  endfunction

  function automatic int prod_hi(input int w);
    return 4 * w - 2;
  endfunction

  function automatic int prod_lo(input int w);
    return 2 * w - 1;
  endfunction

endpackage

// File: rtl/goldschmidt_step.sv
// rtl/goldschmidt_step.sv - one combinational Goldschmidt iteration: both iterates scaled by f = 2 - b
module goldschmidt_step
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [iw(WIDTH)-1:0] i_a,
  input  logic [iw(WIDTH)-1:0] i_b,
  output logic [iw(WIDTH)-1:0] o_a,
  output logic [iw(WIDTH)-1:0] o_b
);

  localparam int IW = iw(WIDTH);
  localparam int PH = prod_hi(WIDTH);
  localparam int PL = prod_lo(WIDTH);

  logic [IW-1:0]   w_f;
  logic [2*IW-1:0] w_pa;
  logic [2*IW-1:0] w_pb;
  logic            w_unused;

  // Two's complement in x.(IW-1) format is exactly 2 - b
  assign w_f  = ~i_b + {{(IW-1){1'b0}}, 1'b1};
  assign w_pa = {{IW{1'b0}}, i_a} * {{IW{1'b0}}, w_f};
  assign w_pb = {{IW{1'b0}}, i_b} * {{IW{1'b0}}, w_f};

  assign o_a = w_pa[PH:PL];
  assign o_b = w_pb[PH:PL];

  assign w_unused = ^{w_pa[2*IW-1], w_pa[PL-1:0], w_pb[2*IW-1], w_pb[PL-1:0]};

endmodule

// File: rtl/goldschmidt_div_param.sv
// rtl/goldschmidt_div_param.sv - iterative Goldschmidt divider for normalised fractions with abort and error flag
module goldschmidt_div_param
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 5,
  parameter int CNT_W = $clog2(ITER + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] yn,
  output logic             busy,
  output logic             ready,
  output logic             err,
  output logic [CNT_W-1:0] count
);

  localparam int             IW   = iw(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_a;
  logic [IW-1:0]    r_b;
  logic [IW-1:0]    w_a_nxt;
  logic [IW-1:0]    w_b_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic             w_norm;
  logic             w_rnd;
  logic [WIDTH:0]   w_q_sum;
  logic             w_unused;

  assign w_norm = a[WIDTH-1] & b[WIDTH-1];

  goldschmidt_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a (r_a),
    .i_b (r_b),
    .o_a (w_a_nxt),
    .o_b (w_b_nxt)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count == LAST) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        if (start) begin
          w_state_nxt = w_norm ? ST_RUN : ST_DONE;
        end
      end
    endcase
  end

  // Start is only honoured outside RUN, so abort automatically takes priority over it
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_a     <= '0;
      r_b     <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (!abort) begin
        r_a     <= w_a_nxt;
        r_b     <= w_b_nxt;
        r_count <= r_count + CNT_W'(1);
      end
    end else if (start) begin
      r_count <= '0;
      r_err   <= ~w_norm;
      if (w_norm) begin
        r_a <= {1'b0, a, {(WIDTH-1){1'b0}}};
        r_b <= {1'b0, b, {(WIDTH-1){1'b0}}};
      end
    end
  end

  // Iterates converge from below, so any set guard bit rounds the quotient up
  assign w_rnd   = |r_a[WIDTH-1:WIDTH-ROUND_BITS];
  assign w_q_sum = {1'b0, r_a[IW-1:WIDTH]} + {{WIDTH{1'b0}}, w_rnd};

  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    case (r_state)
      ST_RUN:  busy  = 1'b1;
      ST_DONE: ready = 1'b1;
      default: ;
    endcase
    if (r_err || w_q_sum[WIDTH]) begin
      q = '1;
    end else begin
      q = w_q_sum[WIDTH-1:0];
    end
  end

  assign yn    = r_b[IW-2:WIDTH-1];
  assign err   = r_err;
  assign count = r_count;

  assign w_unused = ^{r_a[WIDTH-ROUND_BITS-1:0], r_b[IW-1], r_b[WIDTH-2:0]};

endmodule
